// File: rtl/pc_counter_irq.sv
// pc_counter_irq: program counter with priority next-PC select and an irq-written instruction memory
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset (pc <= RESET_PC, memory cleared)
//   irq        hold pc and write instr_in into the word at pc
//   jump       unconditional load of word-aligned pc_target
//   pc_target  jump/branch destination
//   branch     conditional branch, taken when zero_flag is set
//   zero_flag  branch condition
//   up         pc + 8
//   down       pc - 4
//   instr_in   word written while irq is high
//   pc         registered program counter
//   instr_out  combinational read of the word at pc
module pc_counter_irq #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        jump,
    input  logic [31:0] pc_target,
    input  logic        branch,
    input  logic        zero_flag,
    input  logic        up,
    input  logic        down,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] instr_out
);
    localparam int AW = $clog2(IMEM_DEPTH);
    logic [31:0]   mem [IMEM_DEPTH];
    logic [31:0]   pc_next;
    logic [31:0]   target;
    logic [AW-1:0] addr;
    // Upper pc bits are dropped so addresses alias modulo the memory size.
    assign addr      = pc[AW+1:2];
    assign target    = {pc_target[31:2], 2'b00};
    assign instr_out = mem[addr];
    always_comb begin
        pc_next = irq                  ? pc        :
                  jump                 ? target    :
                  branch && zero_flag  ? target    :
                  up                   ? pc + 32'd8 :
                  down                 ? pc - 32'd4 :
                                         pc + 32'd4;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= {RESET_PC[31:2], 2'b00};
            for (int i = 0; i < IMEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            pc <= pc_next;
            if (irq) mem[addr] <= instr_in;
        end
    end
endmodule

// File: tb/tb_pc_counter_irq.sv
// tb_pc_counter_irq: directed self-checking bench for pc_counter_irq
module tb_pc_counter_irq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        irq = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] pc_target = '0;
    logic        branch = 1'b0;
    logic        zero_flag = 1'b0;
    logic        up = 1'b0;
    logic        down = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc;
    logic [31:0] instr_out;
    int          tests = 0;
    int          fails = 0;

    pc_counter_irq #(.IMEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .irq(irq), .jump(jump), .pc_target(pc_target),
        .branch(branch), .zero_flag(zero_flag), .up(up), .down(down),
        .instr_in(instr_in), .pc(pc), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        irq = 0; jump = 0; branch = 0; zero_flag = 0; up = 0; down = 0;
    endtask

    initial begin
        #22;
        chk("reset_pc", pc, 32'h0);
        chk("reset_instr", instr_out, 32'h0);
        reset = 1;
        tick; chk("seq_4", pc, 32'd4);
        tick; chk("seq_8", pc, 32'd8);
        tick; chk("seq_12", pc, 32'd12);
        chk("seq_instr", instr_out, 32'h0);
        irq = 1; instr_in = 32'h1111_1111;
        #1 chk("rdw_old", instr_out, 32'h0);
        tick; chk("irq_hold0", pc, 32'd12);
        chk("irq_first", instr_out, 32'h1111_1111);
        instr_in = 32'hDEAD_BEEF;
        tick; tick; tick;
        chk("irq_hold3", pc, 32'd12);
        chk("irq_last_wins", instr_out, 32'hDEAD_BEEF);
        irq = 0;
        tick; chk("resume_16", pc, 32'd16);
        chk("instr_16", instr_out, 32'h0);
        tick; chk("resume_20", pc, 32'd20);
        jump = 1; pc_target = 32'd12;
        tick; chk("jump_back_12", pc, 32'd12);
        chk("readback_12", instr_out, 32'hDEAD_BEEF);
        pc_target = 32'd20;
        tick; chk("jump_20", pc, 32'd20);
        clr; up = 1;
        tick; chk("up_28", pc, 32'd28);
        clr;
        tick; chk("after_up_32", pc, 32'd32);
        down = 1;
        tick; chk("down_28", pc, 32'd28);
        clr;
        tick; chk("after_down_32", pc, 32'd32);
        up = 1; down = 1;
        tick; chk("up_down_40", pc, 32'd40);
        clr; pc_target = 32'h0000_0103; jump = 1;
        tick; chk("jump_align", pc, 32'h100);
        clr; branch = 1; zero_flag = 0; up = 1;
        tick; chk("br_not_taken_up", pc, 32'h108);
        zero_flag = 1;
        tick; chk("br_taken", pc, 32'h100);
        clr; irq = 1; jump = 1; instr_in = 32'h1234_5678;
        tick; chk("irq_over_jump", pc, 32'h100);
        chk("irq_write_100", instr_out, 32'h1234_5678);
        clr; branch = 1;
        tick; chk("br_alone_seq", pc, 32'h104);
        clr; jump = 1; pc_target = 32'hFFFF_FFFC;
        tick; chk("jump_top", pc, 32'hFFFF_FFFC);
        clr;
        tick; chk("wrap_plus4", pc, 32'h0);
        chk("instr_0", instr_out, 32'h0);
        down = 1;
        tick; chk("wrap_minus4", pc, 32'hFFFF_FFFC);
        clr; jump = 1; pc_target = 32'hFFFF_FFF8;
        tick; clr; up = 1;
        tick; chk("wrap_plus8", pc, 32'h0);
        clr; jump = 1; pc_target = 32'h400;
        tick; chk("jump_400", pc, 32'h400);
        clr; irq = 1; instr_in = 32'hA5A5_A5A5;
        tick; chk("write_400", instr_out, 32'hA5A5_A5A5);
        clr; jump = 1; pc_target = 32'h0;
        tick; chk("alias_0", instr_out, 32'hA5A5_A5A5);
        pc_target = 32'd12;
        tick; chk("pre_rst_pc", pc, 32'd12);
        clr; irq = 1; instr_in = 32'h7777_7777;
        #2 reset = 0;
        #1 chk("async_pc", pc, 32'h0);
        chk("async_instr", instr_out, 32'h0);
        tick; chk("rst_hold_pc", pc, 32'h0);
        chk("rst_hold_instr", instr_out, 32'h0);
        clr; jump = 1; pc_target = 32'd12;
        reset = 1;
        tick; chk("rst_first_jump", pc, 32'd12);
        chk("cleared_12", instr_out, 32'h0);
        pc_target = 32'h100;
        tick; chk("cleared_100", instr_out, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
